// File: rtl/mult_unit.sv
`timescale 1ns/1ps
// Iterative signed WIDTHxWIDTH shift-add multiplier owning the HI/LO pair.
// A product takes WIDTH+1 edges; mfhi/mflo reads stall while it is in flight.
module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             multLoad,
    input  logic             hiloRead,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] product;
    logic               last_step;

    // Magnitudes are unsigned, so |-2^(WIDTH-1)| = 2^(WIDTH-1) is representable.
    always_comb begin
        abs_a     = opA[WIDTH-1] ? (~opA + WIDTH'(1)) : opA;
        abs_b     = opB[WIDTH-1] ? (~opB + WIDTH'(1)) : opB;
        addend    = {{WIDTH{1'b0}}, mag_a} << count;
        product   = neg ? (~acc + (2*WIDTH)'(1)) : acc;
        last_step = (count == CW'(WIDTH - 1));
    end

    assign stall = busy & hiloRead;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: state_next is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (multLoad)  state_next = RUN;
            RUN:     if (last_step) state_next = FIX;
            FIX:                    state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_a <= '0;
            mag_b <= '0;
            neg   <= 1'b0;
            acc   <= '0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (multLoad) begin
                        mag_a <= abs_a;
                        mag_b <= abs_b;
                        neg   <= opA[WIDTH-1] ^ opB[WIDTH-1];
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (mag_b[0]) acc <= acc + addend;
                    mag_b <= mag_b >> 1;
                    count <= count + CW'(1);
                end
                FIX: begin
                    hi   <= product[2*WIDTH-1:WIDTH];
                    lo   <= product[WIDTH-1:0];
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
